// File: rtl/fp_add_arbiter_pkg.sv
// Shared types and width helpers for the floating-point adder arbiter and
// the round-robin picker it is built from.
package fp_arb_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_t;

    function automatic int fp_width(input int exp_len, input int mant_len);
        return exp_len + mant_len + 1;
    endfunction

    // Index width for a requester count, never narrower than one bit.
    function automatic int idx_width(input int num_req);
        return (num_req > 2) ? $clog2(num_req) : 1;
    endfunction

endpackage

// File: rtl/fp_add_arbiter_if.sv
// Requester-side and adder-side signals of the arbiter, bundled as one bus.
// The arbiter uses the slave view; the surrounding stages and adder use master.
interface fp_add_arbiter_if #(
    parameter int EXP_LEN      = 8,
    parameter int MANTISSA_LEN = 23,
    parameter int NUM_REQ      = 4
);
    import fp_arb_pkg::*;

    localparam int W     = fp_width(EXP_LEN, MANTISSA_LEN);
    localparam int IDX_W = idx_width(NUM_REQ);

    logic [NUM_REQ-1:0]          req_start;
    logic [NUM_REQ-1:0][W-1:0]   req_a;
    logic [NUM_REQ-1:0][W-1:0]   req_b;
    logic [W-1:0]                req_sum;
    logic [NUM_REQ-1:0]          req_ready;
    logic [NUM_REQ-1:0]          req_busy;
    logic [NUM_REQ-1:0]          req_overrun;
    logic [W-1:0]                add_a;
    logic [W-1:0]                add_b;
    logic                        add_start;
    logic [W-1:0]                add_sum;
    logic                        add_ready;
    logic [IDX_W-1:0]            active_id;

    modport master (
        output req_start, req_a, req_b, add_sum, add_ready,
        input  req_sum, req_ready, req_busy, req_overrun,
               add_a, add_b, add_start, active_id
    );

    modport slave (
        input  req_start, req_a, req_b, add_sum, add_ready,
        output req_sum, req_ready, req_busy, req_overrun,
               add_a, add_b, add_start, active_id
    );

endinterface

// File: rtl/fp_add_arbiter_rr_pick.sv
// Combinational round-robin picker: first pending index at or after i_ptr,
// wrapping. Shared by the adder and multiplier arbiters.
module rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = 2
) (
    input  logic [NUM_REQ-1:0] i_pending,
    input  logic [IDX_W-1:0]   i_ptr,
    output logic [IDX_W-1:0]   o_grant,
    output logic               o_any
);

    always_comb begin
        int               v_idx;
        logic [IDX_W-1:0] v_sel;
        o_grant = '0;
        o_any   = 1'b0;
        v_idx   = 0;
        v_sel   = '0;
        // Scan from farthest to nearest so the nearest pending slot wins.
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            v_idx = (int'(i_ptr) + k) % NUM_REQ;
            v_sel = IDX_W'(v_idx);
            if (i_pending[v_sel]) begin
                o_grant = v_sel;
                o_any   = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fp_add_arbiter.sv
// Shares one floating-point adder among NUM_REQ requesters: one buffered
// operation per requester, round-robin issue, result returned to its owner.
module fp_add_arbiter
    import fp_arb_pkg::*;
#(
    parameter int EXP_LEN      = 8,
    parameter int MANTISSA_LEN = 23,
    parameter int NUM_REQ      = 4
) (
    input  logic           clock,
    input  logic           reset_n,
    fp_add_arbiter_if.slave bus
);

    localparam int W     = fp_width(EXP_LEN, MANTISSA_LEN);
    localparam int IDX_W = idx_width(NUM_REQ);

    state_t             r_state;
    state_t             w_next_state;
    logic [NUM_REQ-1:0] r_pending;
    logic [NUM_REQ-1:0] r_overrun;
    logic [NUM_REQ-1:0] r_req_ready;
    logic [W-1:0]       r_slot_a [NUM_REQ];
    logic [W-1:0]       r_slot_b [NUM_REQ];
    logic [IDX_W-1:0]   r_rr_ptr;
    logic [IDX_W-1:0]   r_active_id;
    logic [W-1:0]       r_req_sum;
    logic [W-1:0]       r_add_a;
    logic [W-1:0]       r_add_b;
    logic               r_add_start;

    logic [IDX_W-1:0]   w_grant;
    logic               w_any;
    logic               w_issue;
    logic               w_complete;
    logic [NUM_REQ-1:0] w_owner;
    logic [NUM_REQ-1:0] w_clear;
    logic [NUM_REQ-1:0] w_capture;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_pick (
        .i_pending (r_pending),
        .i_ptr     (r_rr_ptr),
        .o_grant   (w_grant),
        .o_any     (w_any)
    );

    always_comb begin
        w_next_state = IDLE;
        w_issue      = 1'b0;
        w_complete   = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_any) begin
                    w_issue      = 1'b1;
                    w_next_state = WAIT;
                end
            end
            WAIT: begin
                if (bus.add_ready) begin
                    w_complete   = 1'b1;
                    w_next_state = IDLE;
                end else begin
                    w_next_state = WAIT;
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    // A completing slot is freed in the same edge, so a start arriving then is a fresh capture.
    always_comb begin
        w_owner = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_owner[i] = (r_active_id == IDX_W'(i));
        end
        w_clear   = w_complete ? w_owner : '0;
        w_capture = bus.req_start & (~r_pending | w_clear);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= IDLE;
            r_pending   <= '0;
            r_overrun   <= '0;
            r_req_ready <= '0;
            r_rr_ptr    <= '0;
            r_active_id <= '0;
            r_req_sum   <= '0;
            r_add_a     <= '0;
            r_add_b     <= '0;
            r_add_start <= 1'b0;
        end else begin
            r_state     <= w_next_state;
            r_pending   <= (r_pending & ~w_clear) | w_capture;
            r_overrun   <= r_overrun | (bus.req_start & r_pending & ~w_clear);
            r_req_ready <= w_clear;
            r_add_start <= w_issue;
            if (w_issue) begin
                r_active_id <= w_grant;
                r_add_a     <= r_slot_a[w_grant];
                r_add_b     <= r_slot_b[w_grant];
            end
            if (w_complete) begin
                r_req_sum <= bus.add_sum;
                r_rr_ptr  <= (r_active_id == IDX_W'(NUM_REQ - 1)) ? '0
                                                                  : r_active_id + IDX_W'(1);
            end
        end
    end

    // Operand slots are pure data; the pending bit alone says whether they are meaningful.
    always_ff @(posedge clock) begin
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_capture[i]) begin
                r_slot_a[i] <= bus.req_a[i];
                r_slot_b[i] <= bus.req_b[i];
            end
        end
    end

    assign bus.req_sum     = r_req_sum;
    assign bus.req_ready   = r_req_ready;
    assign bus.req_busy    = r_pending;
    assign bus.req_overrun = r_overrun;
    assign bus.add_a       = r_add_a;
    assign bus.add_b       = r_add_b;
    assign bus.add_start   = r_add_start;
    assign bus.active_id   = r_active_id;

endmodule
